// File: rtl/alu_mc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_mc : handshaked ALU with iterative shift-add multiply and optional     |
// |          restoring divide (enabled by defining ALU_MC_DIV_EN).             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+

`ifndef ALU_ADD
`define ALU_ADD  0
`define ALU_SUB  1
`define ALU_TH   2
`define ALU_NOT  3
`define ALU_AND  4
`define ALU_OR   5
`define ALU_XOR  6
`define ALU_SRA  7
`define ALU_SRL  8
`define ALU_SLL  9
`define ALU_MUL  10
`define ALU_DIVU 11
`endif
`ifndef N_FLAG
`define N_FLAG 3
`define Z_FLAG 2
`define C_FLAG 1
`define V_FLAG 0
`endif

module alu_mc #(
  parameter int DATA_W = 16,
  parameter int FUNC_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [FUNC_W-1:0] func,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] y,
  output logic [DATA_W-1:0] y_hi,
  output logic [3:0]        flags
);

  localparam int                c_cnt_w   = $clog2(DATA_W);
  localparam logic [c_cnt_w-1:0] c_last   = c_cnt_w'(DATA_W - 1);
  localparam logic [DATA_W-1:0] c_w       = DATA_W'(DATA_W);
  localparam logic [FUNC_W-1:0] c_op_add  = FUNC_W'(`ALU_ADD);
  localparam logic [FUNC_W-1:0] c_op_sub  = FUNC_W'(`ALU_SUB);
  localparam logic [FUNC_W-1:0] c_op_th   = FUNC_W'(`ALU_TH);
  localparam logic [FUNC_W-1:0] c_op_not  = FUNC_W'(`ALU_NOT);
  localparam logic [FUNC_W-1:0] c_op_and  = FUNC_W'(`ALU_AND);
  localparam logic [FUNC_W-1:0] c_op_or   = FUNC_W'(`ALU_OR);
  localparam logic [FUNC_W-1:0] c_op_xor  = FUNC_W'(`ALU_XOR);
  localparam logic [FUNC_W-1:0] c_op_sra  = FUNC_W'(`ALU_SRA);
  localparam logic [FUNC_W-1:0] c_op_srl  = FUNC_W'(`ALU_SRL);
  localparam logic [FUNC_W-1:0] c_op_sll  = FUNC_W'(`ALU_SLL);
  localparam logic [FUNC_W-1:0] c_op_mul  = FUNC_W'(`ALU_MUL);
`ifdef ALU_MC_DIV_EN
  localparam logic [FUNC_W-1:0] c_op_divu = FUNC_W'(`ALU_DIVU);
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               r_state;
  logic                 r_in_ready;
  logic                 r_out_valid;
  logic [DATA_W-1:0]    r_y;
  logic [DATA_W-1:0]    r_y_hi;
  logic [3:0]           r_flags;
  logic [c_cnt_w-1:0]   r_cnt;
  // r_a holds multiplicand or divisor; r_hi/r_lo hold product or remainder/quotient
  logic [DATA_W-1:0]    r_a;
  logic [DATA_W-1:0]    r_hi;
  logic [DATA_W-1:0]    r_lo;

  function automatic logic [3:0] f_flags(input logic [DATA_W-1:0] res,
                                         input logic cf, input logic vf);
    logic [3:0] f;
    f          = 4'b0000;
    f[`N_FLAG] = res[DATA_W-1];
    f[`Z_FLAG] = (res == '0);
    f[`C_FLAG] = cf;
    f[`V_FLAG] = vf;
    return f;
  endfunction

  logic        [DATA_W:0]   w_sum;
  logic        [DATA_W:0]   w_dif;
  logic        [DATA_W:0]   w_shl;
  logic        [DATA_W:0]   w_shr;
  logic signed [DATA_W:0]   w_sra_in;
  logic signed [DATA_W:0]   w_sra;
  logic        [DATA_W-1:0] w_y;
  logic        [DATA_W-1:0] w_y_hi;
  logic                     w_c;
  logic                     w_v;

  assign w_sum    = {1'b0, a} + {1'b0, b};
  assign w_dif    = {1'b0, a} - {1'b0, b};
  // The extra bit beside the data catches the last bit shifted out
  assign w_shl    = {1'b0, a} << b;
  assign w_shr    = {a, 1'b0} >> b;
  assign w_sra_in = {a, 1'b0};
  assign w_sra    = w_sra_in >>> b;

  always_comb begin
    w_y    = '0;
    w_y_hi = '0;
    w_c    = 1'b0;
    w_v    = 1'b0;
    case (func)
      c_op_add: begin
        w_y = w_sum[DATA_W-1:0];
        w_c = w_sum[DATA_W];
        w_v = (a[DATA_W-1] == b[DATA_W-1]) && (w_sum[DATA_W-1] != a[DATA_W-1]);
      end
      c_op_sub: begin
        w_y = w_dif[DATA_W-1:0];
        w_c = w_dif[DATA_W];
        w_v = (a[DATA_W-1] != b[DATA_W-1]) && (w_dif[DATA_W-1] != a[DATA_W-1]);
      end
      c_op_th:  w_y = b;
      c_op_not: w_y = ~b;
      c_op_and: w_y = a & b;
      c_op_or:  w_y = a | b;
      c_op_xor: w_y = a ^ b;
      c_op_sll: begin
        w_y = w_shl[DATA_W-1:0];
        w_c = w_shl[DATA_W];
      end
      c_op_srl: begin
        w_y = w_shr[DATA_W:1];
        w_c = w_shr[0];
      end
      c_op_sra: begin
        w_y = w_sra[DATA_W:1];
        w_c = (b > c_w) ? 1'b0 : w_sra[0];
      end
`ifdef ALU_MC_DIV_EN
      c_op_divu: begin
        w_y    = '1;
        w_y_hi = a;
        w_v    = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  logic [DATA_W:0]   w_mul_sum;
  logic [DATA_W-1:0] w_mul_hi;
  logic [DATA_W-1:0] w_mul_lo;

  assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : '0);
  assign w_mul_hi  = w_mul_sum[DATA_W:1];
  assign w_mul_lo  = {w_mul_sum[0], r_lo[DATA_W-1:1]};

`ifdef ALU_MC_DIV_EN
  logic [DATA_W:0]   w_div_shift;
  logic [DATA_W:0]   w_div_diff;
  logic              w_div_ok;
  logic [DATA_W-1:0] w_div_rem;
  logic [DATA_W-1:0] w_div_quo;

  assign w_div_shift = {r_hi, r_lo[DATA_W-1]};
  assign w_div_diff  = w_div_shift - {1'b0, r_a};
  assign w_div_ok    = ~w_div_diff[DATA_W];
  assign w_div_rem   = w_div_ok ? w_div_diff[DATA_W-1:0] : w_div_shift[DATA_W-1:0];
  assign w_div_quo   = {r_lo[DATA_W-2:0], w_div_ok};
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_y         <= '0;
      r_y_hi      <= '0;
      r_flags     <= 4'b0000;
      r_cnt       <= '0;
      r_a         <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_in_ready <= 1'b0;
            r_cnt      <= '0;
            r_hi       <= '0;
            if (func == c_op_mul) begin
              r_a     <= a;
              r_lo    <= b;
              r_state <= S_MUL;
`ifdef ALU_MC_DIV_EN
            end else if (func == c_op_divu && b != '0) begin
              r_a     <= b;
              r_lo    <= a;
              r_state <= S_DIV;
`endif
            end else begin
              r_y         <= w_y;
              r_y_hi      <= w_y_hi;
              r_flags     <= f_flags(w_y, w_c, w_v);
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end
          end
        end
        S_MUL: begin
          r_hi  <= w_mul_hi;
          r_lo  <= w_mul_lo;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == c_last) begin
            r_y         <= w_mul_lo;
            r_y_hi      <= w_mul_hi;
            r_flags     <= f_flags(w_mul_lo, |w_mul_hi, |w_mul_hi);
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
`ifdef ALU_MC_DIV_EN
        S_DIV: begin
          r_hi  <= w_div_rem;
          r_lo  <= w_div_quo;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == c_last) begin
            r_y         <= w_div_quo;
            r_y_hi      <= w_div_rem;
            r_flags     <= f_flags(w_div_quo, 1'b0, 1'b0);
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
`endif
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_in_ready <= 1'b1;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign y         = r_y;
  assign y_hi      = r_y_hi;
  assign flags     = r_flags;

endmodule

`default_nettype wire
